wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 92 +++++++++
 tb/tb_wb_port_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter between the pipeline writeback and a 2-deep multi-cycle result FIFO
module wb_port_arbiter #(
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_valid,
   input  logic [4:0]  wb_dst,
   input  logic [63:0] wb_data,
   output logic        wb_stall,
   input  logic        mu_valid,
   input  logic [4:0]  mu_dst,
   input  logic [63:0] mu_data,
   output logic        mu_ready,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [63:0] rf_wd
);

   logic [1:0]  occCnt;
   logic        rdPtr;
   logic        wrPtr;
   logic [3:0]  starveCnt;
   logic [4:0]  fifoDst  [2];
   logic [63:0] fifoData [2];

   logic pReq;
   logic fHere;
   logic grantF;
   logic grantP;
   logic enq;
   logic starveHit;

   // x0 writes are architecturally dead, so they never enter arbitration
   assign pReq      = wb_valid && (wb_dst != 5'd0);
   assign fHere     = (occCnt != 2'd0);
   assign starveHit = (starveCnt == 4'(STARVE_MAX));
   assign grantF    = fHere && (!pReq || starveHit);
   assign grantP    = pReq && !grantF;

   assign wb_stall = pReq && grantF && !reset;
   // ready looks only at registered occupancy: a full FIFO refuses even while draining
   assign mu_ready = (occCnt != 2'd2) && !reset;
   assign enq      = mu_valid && mu_ready && (mu_dst != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occCnt    <= 2'd0;
         rdPtr     <= 1'b0;
         wrPtr     <= 1'b0;
         starveCnt <= 4'd0;
         rf_we     <= 1'b0;
         rf_wa     <= 5'd0;
         rf_wd     <= 64'd0;
      end else begin
         occCnt <= occCnt + {1'b0, enq} - {1'b0, grantF};
         if (enq) begin
            wrPtr <= ~wrPtr;
         end
         if (grantF) begin
            rdPtr <= ~rdPtr;
         end

         if (!fHere || grantF) begin
            starveCnt <= 4'd0;
         end else if (grantP) begin
            starveCnt <= starveCnt + 4'd1;
         end

         if (grantF) begin
            rf_we <= 1'b1;
            rf_wa <= fifoDst[rdPtr];
            rf_wd <= fifoData[rdPtr];
         end else if (grantP) begin
            rf_we <= 1'b1;
            rf_wa <= wb_dst;
            rf_wd <= wb_data;
         end else begin
            rf_we <= 1'b0;
         end
      end
   end

   // Storage needs no reset: occupancy gates every read
   always_ff @(posedge clk) begin
      if (enq) begin
         fifoDst[wrPtr]  <= mu_dst;
         fifoData[wrPtr] <= mu_data;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

   localparam int STARVE_MAX = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        wb_valid;
   logic [4:0]  wb_dst;
   logic [63:0] wb_data;
   logic        wb_stall;
   logic        mu_valid;
   logic [4:0]  mu_dst;
   logic [63:0] mu_data;
   logic        mu_ready;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [63:0] rf_wd;

   wb_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data), .wb_stall(wb_stall),
      .mu_valid(mu_valid), .mu_dst(mu_dst), .mu_data(mu_data), .mu_ready(mu_ready),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  dst;
      logic [63:0] data;
   } ent_t;

   typedef struct {
      logic        wv;
      logic [4:0]  wd;
      logic [63:0] wdat;
      logic        mv;
      logic [4:0]  md;
      logic [63:0] mdat;
      logic        eStall;
      logic        eReady;
      logic        eWe;
      logic [4:0]  eWa;
      logic [63:0] eWd;
   } vec_t;

   int nTests = 0;
   int nFail  = 0;

   ent_t        mq[$];
   int          mStarve;
   logic        mWe;
   logic [4:0]  mWa;
   logic [63:0] mWd;
   logic        sStall;
   logic        sReady;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelClear();
      mq.delete();
      mStarve = 0;
      mWe = 1'b0;
      mWa = 5'd0;
      mWd = 64'd0;
   endtask

   // One clock cycle: compare combinational outputs, clock, advance model, compare writes
   task automatic step();
      bit   p, f, gf, rdy, hs;
      ent_t e;
      p   = wb_valid && (wb_dst != 5'd0);
      f   = mq.size() > 0;
      gf  = f && (!p || mStarve == STARVE_MAX);
      rdy = mq.size() < 2;
      hs  = mu_valid && rdy;
      #2;
      sStall = wb_stall;
      sReady = mu_ready;
      chk("model_stall", {63'd0, wb_stall}, {63'd0, p && gf});
      chk("model_ready", {63'd0, mu_ready}, {63'd0, rdy});
      @(posedge clk);
      if (gf) begin
         mWe = 1'b1;
         mWa = mq[0].dst;
         mWd = mq[0].data;
         void'(mq.pop_front());
      end else if (p) begin
         mWe = 1'b1;
         mWa = wb_dst;
         mWd = wb_data;
      end else begin
         mWe = 1'b0;
      end
      if (!f || gf) mStarve = 0;
      else mStarve++;
      if (hs && mu_dst != 5'd0) begin
         e.dst  = mu_dst;
         e.data = mu_data;
         mq.push_back(e);
      end
      #1;
      chk("model_we", {63'd0, rf_we}, {63'd0, mWe});
      chk("model_wa", {59'd0, rf_wa}, {59'd0, mWa});
      chk("model_wd", rf_wd, mWd);
   endtask

   task automatic doReset();
      reset = 1'b1;
      #1;
      chk("rst_ready", {63'd0, mu_ready}, 64'd0);
      chk("rst_stall", {63'd0, wb_stall}, 64'd0);
      chk("rst_we", {63'd0, rf_we}, 64'd0);
      chk("rst_wa", {59'd0, rf_wa}, 64'd0);
      chk("rst_wd", rf_wd, 64'd0);
      modelClear();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic setIn(input logic wv, input logic [4:0] wd, input logic [63:0] wdat,
                        input logic mv, input logic [4:0] md, input logic [63:0] mdat);
      wb_valid = wv; wb_dst = wd; wb_data = wdat;
      mu_valid = mv; mu_dst = md; mu_data = mdat;
   endtask

   vec_t tbl[13];
   ent_t muItems[3];
   int   acceptCyc[3];
   int   muIdx;
   int   nWr;
   int   firstMuWr;
   logic [4:0] wrOrder[3];
   logic readyLog[8];
   bit   sawWrite;

   initial begin
      // P-only, mu-only, starvation with STARVE_MAX=3, then zero-register requests
      tbl[0]  = '{1, 5'd5, 64'hAA, 0, 5'd0, 64'd0,     0, 1, 1, 5'd5, 64'hAA};
      tbl[1]  = '{1, 5'd5, 64'hAA, 0, 5'd0, 64'd0,     0, 1, 1, 5'd5, 64'hAA};
      tbl[2]  = '{0, 5'd0, 64'd0,  1, 5'd7, 64'h1234,  0, 1, 0, 5'd5, 64'hAA};
      tbl[3]  = '{0, 5'd0, 64'd0,  0, 5'd0, 64'd0,     0, 1, 1, 5'd7, 64'h1234};
      tbl[4]  = '{0, 5'd0, 64'd0,  0, 5'd0, 64'd0,     0, 1, 0, 5'd7, 64'h1234};
      tbl[5]  = '{1, 5'd1, 64'h11, 1, 5'd9, 64'h99,    0, 1, 1, 5'd1, 64'h11};
      tbl[6]  = '{1, 5'd1, 64'h11, 0, 5'd0, 64'd0,     0, 1, 1, 5'd1, 64'h11};
      tbl[7]  = '{1, 5'd1, 64'h11, 0, 5'd0, 64'd0,     0, 1, 1, 5'd1, 64'h11};
      tbl[8]  = '{1, 5'd1, 64'h11, 0, 5'd0, 64'd0,     0, 1, 1, 5'd1, 64'h11};
      tbl[9]  = '{1, 5'd1, 64'h11, 0, 5'd0, 64'd0,     1, 1, 1, 5'd9, 64'h99};
      tbl[10] = '{1, 5'd1, 64'h11, 0, 5'd0, 64'd0,     0, 1, 1, 5'd1, 64'h11};
      tbl[11] = '{1, 5'd0, 64'h55, 1, 5'd0, 64'h66,    0, 1, 0, 5'd1, 64'h11};
      tbl[12] = '{0, 5'd0, 64'd0,  0, 5'd0, 64'd0,     0, 1, 0, 5'd1, 64'h11};

      setIn(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
      reset = 1'b1;
      modelClear();
      #1;
      chk("init_ready", {63'd0, mu_ready}, 64'd0);
      chk("init_we", {63'd0, rf_we}, 64'd0);
      chk("init_wa", {59'd0, rf_wa}, 64'd0);
      chk("init_wd", rf_wd, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         setIn(tbl[i].wv, tbl[i].wd, tbl[i].wdat, tbl[i].mv, tbl[i].md, tbl[i].mdat);
         step();
         chk($sformatf("vec%0d_stall", i), {63'd0, sStall}, {63'd0, tbl[i].eStall});
         chk($sformatf("vec%0d_ready", i), {63'd0, sReady}, {63'd0, tbl[i].eReady});
         chk($sformatf("vec%0d_we", i), {63'd0, rf_we}, {63'd0, tbl[i].eWe});
         chk($sformatf("vec%0d_wa", i), {59'd0, rf_wa}, {59'd0, tbl[i].eWa});
         chk($sformatf("vec%0d_wd", i), rf_wd, tbl[i].eWd);
      end

      // Full FIFO under continuous pipeline traffic
      muItems[0] = '{5'd10, 64'hA0};
      muItems[1] = '{5'd11, 64'hB0};
      muItems[2] = '{5'd12, 64'hC0};
      muIdx = 0;
      nWr = 0;
      firstMuWr = -1;
      for (int k = 0; k < 3; k++) acceptCyc[k] = -1;
      for (int c = 0; c < 40 && (muIdx < 3 || nWr < 3); c++) begin
         if (muIdx < 3) setIn(1, 5'd2, 64'h22, 1, muItems[muIdx].dst, muItems[muIdx].data);
         else setIn(1, 5'd2, 64'h22, 0, 5'd0, 64'd0);
         step();
         if (c < 8) readyLog[c] = sReady;
         if (mu_valid && sReady) begin
            acceptCyc[muIdx] = c;
            muIdx++;
         end
         if (rf_we && rf_wa >= 5'd10 && nWr < 3) begin
            if (firstMuWr < 0) firstMuWr = c;
            wrOrder[nWr] = rf_wa;
            nWr++;
         end
      end
      chk("full_all_accepted", muIdx, 3);
      chk("full_all_written", nWr, 3);
      chk("full_ready_low", {63'd0, readyLog[2]}, 64'd0);
      chk("full_third_after_deq", {63'd0, acceptCyc[2] > firstMuWr}, 64'd1);
      if (nWr == 3) begin
         chk("full_order0", {59'd0, wrOrder[0]}, 64'd10);
         chk("full_order1", {59'd0, wrOrder[1]}, 64'd11);
         chk("full_order2", {59'd0, wrOrder[2]}, 64'd12);
      end

      // Reset with two queued entries drops them
      setIn(1, 5'd3, 64'h33, 1, 5'd20, 64'h2020);
      step();
      setIn(1, 5'd3, 64'h33, 1, 5'd21, 64'h2121);
      step();
      chk("rstq_model_depth", mq.size(), 2);
      setIn(1, 5'd3, 64'h33, 0, 5'd0, 64'd0);
      doReset();
      setIn(0, 5'd0, 64'd0, 0, 5'd0, 64'd0);
      sawWrite = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (c == 0) chk("rstq_ready_after", {63'd0, sReady}, 64'd1);
         if (rf_we) sawWrite = 1'b1;
      end
      chk("rstq_no_write", {63'd0, sawWrite}, 64'd0);

      // Randomized traffic against the reference model
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 149) == 0) doReset();
         setIn($urandom_range(0, 3) != 0, 5'($urandom_range(0, 4)), {$urandom, $urandom},
               $urandom_range(0, 2) == 0,
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               {$urandom, $urandom});
         step();
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
